watchdog_reset_req: RTL and testbench

- Keyed watchdog timer that generates a reset request back into the system reset controller's reset input when software stops servicing it.
- Runs from the board clock and board reset, so it survives the system reset it causes.
- Its reset_req output is ORed externally into the controller's reset input.
- Sticky fired flag and fire counter let software identify a watchdog-caused restart.

---
 rtl/watchdog_reset_req_if.sv | 33 +++
 rtl/watchdog_reset_req.sv | 137 +++++++++++++
 tb/tb_watchdog_reset_req.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/watchdog_reset_req_if.sv
`default_nettype none
// ============================================================================
// Module      : watchdog_reset_req_if
// Description : Control/status bundle between software registers and the
//               keyed reset-request watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
interface watchdog_reset_req_if #(
    parameter int unsigned CNT_W = 24
);
    logic             enable;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             kick;
    logic [7:0]       kick_key;
    logic             fired_clr;
    logic             reset_req;
    logic             warn;
    logic             fired;
    logic [3:0]       fire_count;
    logic [CNT_W-1:0] count;

    modport master (
        output enable, load, load_val, kick, kick_key, fired_clr,
        input  reset_req, warn, fired, fire_count, count
    );

    modport slave (
        input  enable, load, load_val, kick, kick_key, fired_clr,
        output reset_req, warn, fired, fire_count, count
    );
endinterface
`default_nettype wire

// File: rtl/watchdog_reset_req.sv
`default_nettype none
// ============================================================================
// Module      : watchdog_reset_req
// Description : Keyed watchdog that pulses a reset request into the system
//               reset controller when software stops servicing it.
// Revision    : 1.0 - initial release
// ============================================================================
module watchdog_reset_req #(
    parameter int unsigned      CNT_W           = 24,
    parameter logic [CNT_W-1:0] DEFAULT_TIMEOUT = 24'd1000000,
    parameter int unsigned      PULSE_LEN       = 16,
    parameter logic [7:0]       KICK_KEY        = 8'hA5,
    parameter bit               LOCK_EN         = 1'b1
) (
    input  wire logic            clk_in,
    input  wire logic            reset_in,
    watchdog_reset_req_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_FIRE     = 2'd2
    } state_t;

    localparam logic [7:0]       c_PULSE_LEN = 8'(PULSE_LEN);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    state_t           r_state,      w_state_nxt;
    logic [CNT_W-1:0] r_reload,     w_reload_nxt;
    logic [CNT_W-1:0] r_count,      w_count_nxt;
    logic             r_reset_req,  w_reset_req_nxt;
    logic             r_warn,       w_warn_nxt;
    logic             r_fired,      w_fired_nxt;
    logic [3:0]       r_fire_count, w_fire_count_nxt;
    logic [7:0]       r_pulse_cnt,  w_pulse_cnt_nxt;
    logic             w_fire;
    logic             w_kick_ok;

    assign w_kick_ok = bus.kick && (bus.kick_key == KICK_KEY);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state      <= ST_DISABLED;
            r_reload     <= DEFAULT_TIMEOUT;
            r_count      <= DEFAULT_TIMEOUT;
            r_reset_req  <= 1'b0;
            r_warn       <= 1'b0;
            r_fired      <= 1'b0;
            r_fire_count <= 4'd0;
            r_pulse_cnt  <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_reload     <= w_reload_nxt;
            r_count      <= w_count_nxt;
            r_reset_req  <= w_reset_req_nxt;
            r_warn       <= w_warn_nxt;
            r_fired      <= w_fired_nxt;
            r_fire_count <= w_fire_count_nxt;
            r_pulse_cnt  <= w_pulse_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_reload_nxt     = r_reload;
        w_count_nxt      = r_count;
        w_reset_req_nxt  = r_reset_req;
        w_warn_nxt       = 1'b0;
        w_fired_nxt      = r_fired;
        w_fire_count_nxt = r_fire_count;
        w_pulse_cnt_nxt  = r_pulse_cnt;
        w_fire           = 1'b0;

        // A fire entry below overrides this clear.
        if (bus.fired_clr) begin
            w_fired_nxt = 1'b0;
        end

        case (r_state)
            ST_DISABLED: begin
                if (bus.load) begin
                    w_reload_nxt = (bus.load_val == '0) ? c_ONE : bus.load_val;
                end
                w_count_nxt = w_reload_nxt;
                if (bus.enable) begin
                    w_state_nxt = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (!LOCK_EN && !bus.enable) begin
                    w_state_nxt = ST_DISABLED;
                    w_count_nxt = r_reload;
                end else if (w_kick_ok) begin
                    w_count_nxt = r_reload;
                end else if (bus.kick) begin
                    w_fire = 1'b1;
                end else if (r_count == '0) begin
                    w_fire = 1'b1;
                end else begin
                    w_count_nxt = r_count - c_ONE;
                    w_warn_nxt  = (r_count < (r_reload >> 1));
                end
            end
            ST_FIRE: begin
                if (r_pulse_cnt >= c_PULSE_LEN) begin
                    w_state_nxt     = ST_DISABLED;
                    w_reset_req_nxt = 1'b0;
                    w_count_nxt     = r_reload;
                    w_pulse_cnt_nxt = 8'd0;
                end else begin
                    w_pulse_cnt_nxt = r_pulse_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt     = ST_DISABLED;
                w_reset_req_nxt = 1'b0;
            end
        endcase

        if (w_fire) begin
            w_state_nxt      = ST_FIRE;
            w_reset_req_nxt  = 1'b1;
            w_fired_nxt      = 1'b1;
            w_pulse_cnt_nxt  = 8'd1;
            w_fire_count_nxt = (r_fire_count == 4'd15) ? 4'd15 : r_fire_count + 4'd1;
        end
    end

    assign bus.reset_req  = r_reset_req;
    assign bus.warn       = r_warn;
    assign bus.fired      = r_fired;
    assign bus.fire_count = r_fire_count;
    assign bus.count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_watchdog_reset_req.sv
`default_nettype none
// ============================================================================
// Module      : tb_watchdog_reset_req
// Description : Directed self-checking bench for the reset-request watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_watchdog_reset_req;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    watchdog_reset_req_if #(.CNT_W(24)) bus ();

    watchdog_reset_req #(
        .CNT_W          (24),
        .DEFAULT_TIMEOUT(24'd20),
        .PULSE_LEN      (4),
        .KICK_KEY       (8'hA5),
        .LOCK_EN        (1'b1)
    ) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset;
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.load      = 1'b0;
        bus.load_val  = '0;
        bus.kick      = 1'b0;
        bus.kick_key  = 8'hA5;
        bus.fired_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.load      = 1'b0;
        bus.load_val  = '0;
        bus.kick      = 1'b0;
        bus.kick_key  = 8'hA5;
        bus.fired_clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.reset_req !== 1'b0) begin n_fail++; $display("FAIL rst_reset_req: got %0d expected 0", bus.reset_req); end
        n_checks++;
        if (bus.warn !== 1'b0) begin n_fail++; $display("FAIL rst_warn: got %0d expected 0", bus.warn); end
        n_checks++;
        if (bus.fired !== 1'b0) begin n_fail++; $display("FAIL rst_fired: got %0d expected 0", bus.fired); end
        n_checks++;
        if (bus.fire_count !== 4'd0) begin n_fail++; $display("FAIL rst_fire_count: got %0d expected 0", bus.fire_count); end
        n_checks++;
        if (bus.count !== 24'd20) begin n_fail++; $display("FAIL rst_count: got %0d expected 20", bus.count); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.count !== 24'd20) begin n_fail++; $display("FAIL idle_count: got %0d expected 20", bus.count); end
    endtask

    task automatic test_timeout;
        logic       exp_rr;
        logic       exp_warn;
        do_reset();
        bus.enable = 1'b1;
        for (int c = 0; c <= 27; c++) begin
            @(negedge clk);
            exp_rr   = (c >= 21 && c <= 24);
            exp_warn = (c >= 12 && c <= 20);
            n_checks++;
            if (bus.reset_req !== exp_rr) begin n_fail++; $display("FAIL timeout_reset_req c=%0d: got %0d expected %0d", c, bus.reset_req, exp_rr); end
            if (c <= 24) begin
                n_checks++;
                if (bus.warn !== exp_warn) begin n_fail++; $display("FAIL timeout_warn c=%0d: got %0d expected %0d", c, bus.warn, exp_warn); end
            end
            if (c <= 20) begin
                n_checks++;
                if (bus.count !== 24'(20 - c)) begin n_fail++; $display("FAIL timeout_count c=%0d: got %0d expected %0d", c, bus.count, 20 - c); end
            end
            if (c >= 25) begin
                n_checks++;
                if (bus.count !== 24'd20) begin n_fail++; $display("FAIL timeout_count_after c=%0d: got %0d expected 20", c, bus.count); end
            end
            if (c == 21) begin
                n_checks++;
                if (bus.fired !== 1'b1) begin n_fail++; $display("FAIL timeout_fired: got %0d expected 1", bus.fired); end
                n_checks++;
                if (bus.fire_count !== 4'd1) begin n_fail++; $display("FAIL timeout_fire_count: got %0d expected 1", bus.fire_count); end
                bus.enable = 1'b0;
            end
        end
    endtask

    task automatic test_kick;
        int   since;
        int   old;
        logic exp_warn;
        logic warn_seen;
        do_reset();
        bus.enable = 1'b1;
        @(negedge clk);
        since     = 0;
        warn_seen = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            bus.kick = (since == 14);
            @(negedge clk);
            old = since;
            if (bus.kick) begin
                since    = 0;
                exp_warn = 1'b0;
            end else begin
                exp_warn = ((20 - old) < 10);
                since    = old + 1;
            end
            n_checks++;
            if (bus.reset_req !== 1'b0) begin n_fail++; $display("FAIL kick_reset_req cyc=%0d: got %0d expected 0", cyc, bus.reset_req); end
            n_checks++;
            if (bus.count !== 24'(20 - since)) begin n_fail++; $display("FAIL kick_count cyc=%0d: got %0d expected %0d", cyc, bus.count, 20 - since); end
            n_checks++;
            if (bus.warn !== exp_warn) begin n_fail++; $display("FAIL kick_warn cyc=%0d: got %0d expected %0d", cyc, bus.warn, exp_warn); end
            if (bus.warn === 1'b1) warn_seen = 1'b1;
        end
        bus.kick = 1'b0;
        n_checks++;
        if (warn_seen !== 1'b1) begin n_fail++; $display("FAIL kick_warn_seen: got %0d expected 1", warn_seen); end
    endtask

    task automatic test_bad_key;
        bus.kick     = 1'b1;
        bus.kick_key = 8'h5A;
        @(negedge clk);
        n_checks++;
        if (bus.reset_req !== 1'b1) begin n_fail++; $display("FAIL badkey_reset_req: got %0d expected 1", bus.reset_req); end
        n_checks++;
        if (bus.fired !== 1'b1) begin n_fail++; $display("FAIL badkey_fired: got %0d expected 1", bus.fired); end
        n_checks++;
        if (bus.fire_count !== 4'd1) begin n_fail++; $display("FAIL badkey_fire_count: got %0d expected 1", bus.fire_count); end
        bus.kick     = 1'b0;
        bus.kick_key = 8'hA5;
        bus.enable   = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.reset_req !== 1'b0) begin n_fail++; $display("FAIL badkey_release: got %0d expected 0", bus.reset_req); end
    endtask

    task automatic test_load;
        do_reset();
        bus.load     = 1'b1;
        bus.load_val = 24'd0;
        @(negedge clk);
        n_checks++;
        if (bus.count !== 24'd1) begin n_fail++; $display("FAIL load_zero_count: got %0d expected 1", bus.count); end
        bus.load   = 1'b0;
        bus.enable = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.count !== 24'd1) begin n_fail++; $display("FAIL load_run_count: got %0d expected 1", bus.count); end
        bus.load     = 1'b1;
        bus.load_val = 24'd50;
        @(negedge clk);
        n_checks++;
        if (bus.count !== 24'd0 || bus.reset_req !== 1'b0) begin n_fail++; $display("FAIL load_e1: got count %0d rr %0d expected count 0 rr 0", bus.count, bus.reset_req); end
        bus.load = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.reset_req !== 1'b1) begin n_fail++; $display("FAIL load_fire: got %0d expected 1", bus.reset_req); end
        bus.enable = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.reset_req !== 1'b0) begin n_fail++; $display("FAIL load_release: got %0d expected 0", bus.reset_req); end
        n_checks++;
        if (bus.count !== 24'd1) begin n_fail++; $display("FAIL load_reload_kept: got %0d expected 1", bus.count); end
    endtask

    task automatic test_kick_at_zero;
        do_reset();
        bus.load     = 1'b1;
        bus.load_val = 24'd5;
        @(negedge clk);
        bus.load   = 1'b0;
        bus.enable = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (bus.count !== 24'd0) begin n_fail++; $display("FAIL zero_reach: got %0d expected 0", bus.count); end
        bus.kick = 1'b1;
        @(negedge clk);
        bus.kick = 1'b0;
        n_checks++;
        if (bus.reset_req !== 1'b0) begin n_fail++; $display("FAIL zero_kick_rr: got %0d expected 0", bus.reset_req); end
        n_checks++;
        if (bus.count !== 24'd5) begin n_fail++; $display("FAIL zero_kick_count: got %0d expected 5", bus.count); end
        n_checks++;
        if (bus.fired !== 1'b0) begin n_fail++; $display("FAIL zero_kick_fired: got %0d expected 0", bus.fired); end
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.count !== 24'd0) begin n_fail++; $display("FAIL zero_reach2: got %0d expected 0", bus.count); end
        bus.fired_clr = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.reset_req !== 1'b1 || bus.fired !== 1'b1) begin n_fail++; $display("FAIL clr_vs_fire: got rr %0d fired %0d expected 1 1", bus.reset_req, bus.fired); end
        @(negedge clk);
        bus.fired_clr = 1'b0;
        bus.enable    = 1'b0;
        n_checks++;
        if (bus.fired !== 1'b0) begin n_fail++; $display("FAIL clr_fired: got %0d expected 0", bus.fired); end
        n_checks++;
        if (bus.fire_count !== 4'd1) begin n_fail++; $display("FAIL clr_fire_count: got %0d expected 1", bus.fire_count); end
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.reset_req !== 1'b0) begin n_fail++; $display("FAIL clr_release: got %0d expected 0", bus.reset_req); end
    endtask

    task automatic test_saturate;
        int   rises;
        int   exp_fc;
        logic prev;
        do_reset();
        bus.enable   = 1'b1;
        bus.kick     = 1'b1;
        bus.kick_key = 8'h5A;
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 300 && rises < 17; i++) begin
            @(negedge clk);
            if (bus.reset_req === 1'b1 && prev === 1'b0) begin
                rises++;
                exp_fc = (rises > 15) ? 15 : rises;
                n_checks++;
                if (bus.fire_count !== 4'(exp_fc)) begin n_fail++; $display("FAIL sat_fire_count n=%0d: got %0d expected %0d", rises, bus.fire_count, exp_fc); end
            end
            prev = bus.reset_req;
        end
        n_checks++;
        if (rises != 17) begin n_fail++; $display("FAIL sat_fires_seen: got %0d expected 17", rises); end
        bus.enable   = 1'b0;
        bus.kick     = 1'b0;
        bus.kick_key = 8'hA5;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.reset_req !== 1'b0) begin n_fail++; $display("FAIL async_reset_req: got %0d expected 0", bus.reset_req); end
        n_checks++;
        if (bus.fire_count !== 4'd0) begin n_fail++; $display("FAIL async_fire_count: got %0d expected 0", bus.fire_count); end
        n_checks++;
        if (bus.fired !== 1'b0) begin n_fail++; $display("FAIL async_fired: got %0d expected 0", bus.fired); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        test_reset();
        test_timeout();
        test_kick();
        test_bad_key();
        test_load();
        test_kick_at_zero();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
